eigen_angle_cordic: RTL

EIGEN_ANGLE_CORDIC -- requirements
Module: eigen_angle_cordic

---
 rtl/doa_angle_pkg.sv | 8 +
 rtl/eigen_angle_cordic.sv | 138 +++++++++++++
 2 files changed

// File: rtl/doa_angle_pkg.sv
// doa_angle_pkg: FSM encoding and CORDIC constants shared by eigen_angle_cordic.
// Angles are in radians with 13 fractional bits.
package doa_angle_pkg;
    typedef enum logic [1:0] {S_IDLE, S_PRE, S_ITER, S_DONE} state_e;
    localparam int PI = 25736;
    localparam int ATAN [16] = '{6434, 3798, 2007, 1019, 511, 256, 128, 64,
                                 32, 16, 8, 4, 2, 1, 0, 0};
endpackage

// File: rtl/eigen_angle_cordic.sv
// eigen_angle_cordic: picks the dominant eigenvector and returns its atan2 angle
// using an iterative vectoring CORDIC with quadrant pre-rotation.
module eigen_angle_cordic
    import doa_angle_pkg::*;
#(
    parameter int DIN_WIDTH  = 16,
    parameter int DIN_POINT  = 13,
    parameter int DOUT_WIDTH = 16,
    parameter int DOUT_POINT = 13,
    parameter int ITERATIONS = 14
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic signed [DIN_WIDTH-1:0]  lamb1,
    input  logic signed [DIN_WIDTH-1:0]  lamb2,
    input  logic signed [DIN_WIDTH-1:0]  eigen1_y,
    input  logic signed [DIN_WIDTH-1:0]  eigen2_y,
    input  logic signed [DIN_WIDTH-1:0]  eigen_x,
    input  logic                         din_valid,
    input  logic                         din_error,
    output logic                         din_ready,
    output logic signed [DOUT_WIDTH-1:0] angle,
    output logic signed [DIN_WIDTH-1:0]  lamb_max,
    output logic                         dout_valid,
    output logic                         dout_error
);
    localparam int XW = DIN_WIDTH + 2;
    localparam int ZW = DOUT_WIDTH + 1;
    localparam int CW = $clog2(ITERATIONS + 1);

    if (ITERATIONS < 1 || ITERATIONS > DOUT_POINT + 1 || DIN_POINT >= DIN_WIDTH) begin : g_bad_param
        $error("eigen_angle_cordic: illegal parameter combination");
    end

    state_e                        state_q, state_d;
    logic        [CW-1:0]          i_q, i_d;
    logic signed [XW-1:0]          x_q, x_d, y_q, y_d;
    logic signed [ZW-1:0]          z_q, z_d;
    logic                          err_q, err_d;
    logic signed [DIN_WIDTH-1:0]   lsel_q, lsel_d;
    logic signed [DOUT_WIDTH-1:0]  angle_q, angle_d;
    logic signed [DIN_WIDTH-1:0]   lamb_max_q, lamb_max_d;
    logic                          dout_valid_q, dout_valid_d;
    logic                          dout_error_q, dout_error_d;

    logic                          pick1, dir;
    logic signed [DIN_WIDTH-1:0]   sel_y;
    logic signed [ZW-1:0]          atan_v, z_sat_src;
    logic signed [DOUT_WIDTH-1:0]  z_sat;

    assign din_ready = (state_q == S_IDLE);
    assign pick1     = (lamb1 >= lamb2);
    assign sel_y     = pick1 ? eigen1_y : eigen2_y;
    // y >= 0 rotates clockwise to drive y toward zero
    assign dir       = ~y_q[XW-1];
    assign atan_v    = ZW'(ATAN[i_q]);
    assign z_sat_src = z_q;
    assign z_sat     = (z_sat_src[ZW-1] != z_sat_src[ZW-2])
                     ? {z_sat_src[ZW-1], {(DOUT_WIDTH-1){~z_sat_src[ZW-1]}}}
                     : z_sat_src[DOUT_WIDTH-1:0];

    always_comb begin
        state_d      = state_q;
        i_d          = i_q;
        x_d          = x_q;
        y_d          = y_q;
        z_d          = z_q;
        err_d        = err_q;
        lsel_d       = lsel_q;
        angle_d      = angle_q;
        lamb_max_d   = lamb_max_q;
        dout_error_d = dout_error_q;
        dout_valid_d = 1'b0;
        case (state_q)
            S_IDLE: if (din_valid) begin
                x_d     = XW'(eigen_x);
                y_d     = XW'(sel_y);
                lsel_d  = pick1 ? lamb1 : lamb2;
                err_d   = din_error || (eigen_x == '0 && sel_y == '0);
                state_d = S_PRE;
            end
            S_PRE: begin
                x_d     = x_q[XW-1] ? -x_q : x_q;
                y_d     = x_q[XW-1] ? -y_q : y_q;
                z_d     = !x_q[XW-1] ? '0 : (y_q[XW-1] ? -ZW'(PI) : ZW'(PI));
                i_d     = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                x_d     = dir ? x_q + (y_q >>> i_q) : x_q - (y_q >>> i_q);
                y_d     = dir ? y_q - (x_q >>> i_q) : y_q + (x_q >>> i_q);
                z_d     = dir ? z_q + atan_v : z_q - atan_v;
                i_d     = i_q + CW'(1);
                state_d = (i_q == CW'(ITERATIONS - 1)) ? S_DONE : S_ITER;
            end
            default: begin
                angle_d      = err_q ? '0 : z_sat;
                lamb_max_d   = lsel_q;
                dout_error_d = err_q;
                dout_valid_d = 1'b1;
                state_d      = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            i_q          <= '0;
            x_q          <= '0;
            y_q          <= '0;
            z_q          <= '0;
            err_q        <= 1'b0;
            lsel_q       <= '0;
            angle_q      <= '0;
            lamb_max_q   <= '0;
            dout_valid_q <= 1'b0;
            dout_error_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            i_q          <= i_d;
            x_q          <= x_d;
            y_q          <= y_d;
            z_q          <= z_d;
            err_q        <= err_d;
            lsel_q       <= lsel_d;
            angle_q      <= angle_d;
            lamb_max_q   <= lamb_max_d;
            dout_valid_q <= dout_valid_d;
            dout_error_q <= dout_error_d;
        end
    end

    assign angle      = angle_q;
    assign lamb_max   = lamb_max_q;
    assign dout_valid = dout_valid_q;
    assign dout_error = dout_error_q;
endmodule
